// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter and its decode path.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder2to4.sv
// Enabled 2-to-4 one-hot decoder; all-zero output when disabled.
module decoder2to4 (
  input  logic [1:0] a,
  input  logic       en,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) y = 4'b0001 << a;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a bounded grant hold time.
// Grant outputs depend only on registered state, so they change one edge after the decision.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  // Returns {found, index}: first set bit scanning p+1, p+2, p+3, p (mod 4).
  function automatic logic [IDX_W:0] rr_search(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = p + IDX_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  arb_state_e         state_p0, state_p1;
  logic [IDX_W-1:0]   ptr_p0, ptr_p1;
  logic [CNT_W-1:0]   cnt_p0, cnt_p1;
  logic [NUM_REQ-1:0] others;
  logic [IDX_W:0]     win_all, win_oth;
  logic               vld_p1;

  // Stage p1: state register; ptr doubles as the current owner while in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      ptr_p1   <= IDX_W'(NUM_REQ - 1);
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_p0;
      ptr_p1   <= ptr_p0;
      cnt_p1   <= cnt_p0;
    end
  end

  // Stage p0: next-state decision from the sampled requests.
  always_comb begin
    others   = req & ~(NUM_REQ'(1) << ptr_p1);
    win_all  = rr_search(req, ptr_p1);
    win_oth  = rr_search(others, ptr_p1);
    state_p0 = state_p1;
    ptr_p0   = ptr_p1;
    cnt_p0   = cnt_p1;
    case (state_p1)
      IDLE: begin
        if (en && win_all[IDX_W]) begin
          state_p0 = GRANT;
          ptr_p0   = win_all[IDX_W-1:0];
          cnt_p0   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!en) begin
          state_p0 = IDLE;
          cnt_p0   = '0;
        end else if (!req[ptr_p1] || (cnt_p1 == CNT_MAX && |others)) begin
          // Handoff excludes the owner, so a timed-out owner waits its turn.
          if (win_oth[IDX_W]) begin
            ptr_p0 = win_oth[IDX_W-1:0];
            cnt_p0 = CNT_W'(1);
          end else begin
            state_p0 = IDLE;
            cnt_p0   = '0;
          end
        end else begin
          cnt_p0 = sat_inc(cnt_p1);
        end
      end
      default: state_p0 = IDLE;
    endcase
  end

  always_comb begin
    vld_p1    = (state_p1 == GRANT);
    gnt_valid = vld_p1;
    gnt_id    = vld_p1 ? ptr_p1 : '0;
  end

  decoder2to4 u_dec (
    .a  (ptr_p1),
    .en (vld_p1),
    .y  (gnt)
  );

endmodule
